button_intr_ctrl: RTL and testbench

Parametrised front-end that turns N active-low push-buttons into prioritised, vectored interrupt requests for the processor core in the data-logger top level. Each channel is synchronised, debounced and edge-detected. A press latches a pending bit, and a request/acknowledge handshake delivers one vector at a time to the CPU. It generalises the fixed 4-button, polled input path to N channels, with masking, a programmable debounce length and a latched-vector handshake.

---
 rtl/button_intr_ctrl_pkg.sv | 13 +
 rtl/button_intr_ctrl_debounce.sv | 52 +++++
 rtl/button_intr_ctrl.sv | 108 ++++++++++
 tb/tb_button_intr_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/button_intr_ctrl_pkg.sv
// Shared definitions for the push-button interrupt front-end:
// handshake FSM encodings and the board-clock debounce default.
package button_intr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 8;

endpackage

// File: rtl/button_intr_ctrl_debounce.sv
// Single-channel button conditioner: 2-flop synchroniser, saturating-free
// debounce counter, debounced level and a one-cycle press pulse.
module btn_debounce
  import button_intr_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sample;

  assign w_sample = ~r_sync2;

  // The counter stops at DEBOUNCE_CYCLES-1, where the level flips and it clears.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (w_sample == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
        r_press <= ~r_level;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/button_intr_ctrl.sv
// N-channel push-button front-end: debounced presses latch pending bits,
// served one vector at a time to the CPU through an irq/ack handshake.
module button_intr_ctrl
  import button_intr_ctrl_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 4,
  parameter int VEC_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  buttons,
  input  logic [N_CH-1:0]  intr_mask,
  input  logic             intr_ack,
  output logic             irq,
  output logic [VEC_W-1:0] irq_vec,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  btn_state
);

  logic [N_CH-1:0]  w_level;
  logic [N_CH-1:0]  w_press;
  logic [N_CH-1:0]  w_req;
  logic [N_CH-1:0]  w_clr;
  logic [N_CH-1:0]  r_pending;
  logic             r_irq;
  logic [VEC_W-1:0] r_vec;
  state_t           r_state;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .i_clk  (clk),
      .i_rst  (reset),
      .i_btn_n(buttons[g]),
      .o_level(w_level[g]),
      .o_press(w_press[g])
    );
  end

  // Lowest index wins: scan downwards so the last hit is the smallest.
  function automatic logic [VEC_W-1:0] f_prio(input logic [N_CH-1:0] req);
    logic [VEC_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = VEC_W'(i);
    end
    return idx;
  endfunction

  assign w_req = r_pending & intr_mask;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_clr[i] = (r_state == ST_REQ) && intr_ack && (r_vec == VEC_W'(i));
    end
  end

  // A new press in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | (w_press & intr_mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_irq   <= 1'b0;
      r_vec   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_vec   <= f_prio(w_req);
            r_irq   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (intr_ack) begin
            r_irq   <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!intr_ack) r_state <= ST_IDLE;
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq       = r_irq;
  assign irq_vec   = r_vec;
  assign pending   = r_pending;
  assign btn_state = w_level;

endmodule

// File: tb/tb_button_intr_ctrl.sv
// Scoreboard bench for button_intr_ctrl: expected vectors are queued as
// presses are driven and popped when irq rises.
module tb_button_intr_ctrl;

  localparam int N_CH  = 4;
  localparam int VEC_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_CH-1:0]  buttons;
  logic [N_CH-1:0]  intr_mask;
  logic             intr_ack;
  logic             irq;
  logic [VEC_W-1:0] irq_vec;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  btn_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [VEC_W-1:0] exp_q[$];
  logic prev_irq = 1'b0;

  button_intr_ctrl #(
    .N_CH (N_CH),
    .VEC_W(VEC_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .buttons  (buttons),
    .intr_mask(intr_mask),
    .intr_ack (intr_ack),
    .irq      (irq),
    .irq_vec  (irq_vec),
    .pending  (pending),
    .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every rising irq must match the oldest queued vector.
  always @(negedge clk) begin
    if (!reset && irq && !prev_irq) begin
      if (exp_q.size() == 0) chk("unexpected_irq", {28'd0, irq_vec}, 32'hFFFF_FFFF);
      else chk("sb_vec", irq_vec, exp_q.pop_front());
    end
    prev_irq = irq;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_irq();
    int k;
    k = 0;
    while (!irq && k < 40) begin
      tick();
      k++;
    end
    if (!irq) chk("irq_timeout", 0, 1);
  endtask

  task automatic handshake(input logic [VEC_W-1:0] vec, input logic [N_CH-1:0] pend_after);
    wait_irq();
    chk("hs_vec", irq_vec, vec);
    intr_ack = 1'b1;
    tick();
    chk("hs_irq_low", irq, 0);
    chk("hs_pending", pending, pend_after);
    tick();
    chk("hs_wait_irq", irq, 0);
    intr_ack = 1'b0;
    tick();
    chk("hs_gap_irq", irq, 0);
  endtask

  initial begin
    reset     = 1'b1;
    buttons   = '1;
    intr_mask = '1;
    intr_ack  = 1'b0;
    tick(2);
    chk("rst_irq", irq, 0);
    chk("rst_vec", irq_vec, 0);
    chk("rst_pending", pending, 0);
    chk("rst_btn", btn_state, 0);
    reset = 1'b0;

    // Idle: released buttons, all channels enabled.
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle", {irq, pending, btn_state}, 0);
    end

    // Glitch shorter than the debounce window.
    buttons = 4'b1110;
    tick(5);
    buttons = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("glitch_btn", btn_state, 0);
      chk("glitch_pend", pending, 0);
    end

    // Single press on channel 0 with exact latency.
    exp_q.push_back(4'd0);
    buttons = 4'b1110;
    tick(9);
    chk("press_btn_early", btn_state[0], 0);
    tick();
    chk("press_btn", btn_state, 4'b0001);
    tick();
    chk("press_pending", pending, 4'b0001);
    chk("press_irq_early", irq, 0);
    tick();
    chk("press_irq", irq, 1);
    chk("press_vec", irq_vec, 0);
    handshake(4'd0, 4'b0000);
    buttons = 4'b1111;
    tick(12);
    chk("release_btn", btn_state, 0);
    chk("release_pend", pending, 0);
    chk("release_irq", irq, 0);

    // Two simultaneous presses, served in priority order.
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd3);
    buttons = 4'b0101;
    tick(11);
    chk("prio_pending", pending, 4'b1010);
    handshake(4'd1, 4'b1000);
    tick();
    chk("prio_second_irq", irq, 1);
    handshake(4'd3, 4'b0000);
    buttons = 4'b1111;
    tick(12);

    // Masked press is discarded, not deferred.
    intr_mask = 4'b1011;
    buttons   = 4'b1011;
    tick(14);
    chk("mask_btn", btn_state, 4'b0100);
    chk("mask_pend", pending, 0);
    intr_mask = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mask_irq", irq, 0);
    end
    buttons = 4'b1111;
    tick(12);

    // Reset in the middle of a request.
    exp_q.push_back(4'd1);
    buttons = 4'b1101;
    wait_irq();
    chk("mid_vec", irq_vec, 1);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_pend", pending, 0);
    buttons = 4'b1111;
    tick(3);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("post_rst", {irq, pending}, 0);
    end

    // A fresh press after reset is served normally.
    exp_q.push_back(4'd2);
    buttons = 4'b1011;
    handshake(4'd2, 4'b0000);
    buttons = 4'b1111;
    tick(12);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
